// File: rtl/biu_controller_if.sv
// Bus interfaces used by biu_controller.
//
// biu_master_if : requesting device <-> BIU
//   address, data_out, rnw, en   device -> BIU (request)
//   data_in, data_valid, busy    BIU -> device (response)
// biu_slave_if  : BIU <-> memory-mapped slave
//   address, data_out, rnw, en   BIU -> slave (request replay)
//   data_in, data_valid          slave -> BIU (completion)

interface biu_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rnw;
    logic                  en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  busy;

    modport biu (
        input  address, data_out, rnw, en,
        output data_in, data_valid, busy
    );

    modport dev (
        output address, data_out, rnw, en,
        input  data_in, data_valid, busy
    );
endinterface

interface biu_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rnw;
    logic                  en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;

    modport biu (
        output address, data_out, rnw, en,
        input  data_in, data_valid
    );

    modport dev (
        input  address, data_out, rnw, en,
        output data_in, data_valid
    );
endinterface

// File: rtl/biu_controller.sv
// Bus interface unit: accepts single read/write requests from one device,
// replays each on the slave bus, waits for the slave completion (or a
// programmable timeout) and returns read data to the device.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   master       biu_master_if.biu - request side
//   slave        biu_slave_if.biu  - slave side
//   timeout_err  one-cycle pulse when a transfer is aborted by timeout
//   dbg_state    current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
//
// Handshake: the device may present a request (master.en=1) whenever
// busy=0; the request is taken on that clock edge only in IDLE or RESP.
// While busy=1 master.en is ignored and must be re-presented later.
// The BIU raises slave.en for exactly one cycle per transfer; the slave
// completes with slave.data_valid=1 for one cycle, no earlier than the
// cycle after slave.en. Reads return with master.data_valid=1 in the cycle
// busy falls; writes complete silently when busy falls.

module biu_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA = DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic        clk,
    input  logic        n_rst,
    biu_master_if.biu   master,
    biu_slave_if.biu    slave,
    output logic        timeout_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Counter wide enough to hold TIMEOUT_CYCLES; at least one bit so a
    // disabled timeout still gives a legal vector.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rnw_q, rnw_d;
    logic                  sen_q, sen_d;
    logic                  busy_q, busy_d;
    logic                  dv_q, dv_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  terr_q, terr_d;

    logic accept;
    logic timeout_hit;

    // A new request is taken only when the unit is not busy.
    assign accept      = master.en && ((state_q == S_IDLE) || (state_q == S_RESP));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rnw_q   <= 1'b0;
            sen_q   <= 1'b0;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            rdata_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rnw_q   <= rnw_d;
            sen_q   <= sen_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
            rdata_q <= rdata_d;
            terr_q  <= terr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: if (slave.data_valid || timeout_hit) state_d = S_RESP;
            S_RESP: state_d = accept ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs. Strobes derive
    // from the next state so they line up with the state they describe.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rnw_d   = rnw_q;
        rdata_d = rdata_q;
        dv_d    = 1'b0;
        terr_d  = 1'b0;
        sen_d   = (state_d == S_REQ);
        busy_d  = (state_d == S_REQ) || (state_d == S_WAIT);

        if (accept) begin
            addr_d  = master.address;
            wdata_d = master.data_out;
            rnw_d   = master.rnw;
        end

        case (state_q)
            S_REQ: cnt_d = '0;
            S_WAIT: begin
                // Slave completion takes priority over a coincident timeout.
                if (slave.data_valid) begin
                    if (rnw_q) begin
                        rdata_d = slave.data_in;
                        dv_d    = 1'b1;
                    end
                end else if (timeout_hit) begin
                    terr_d = 1'b1;
                    if (rnw_q) begin
                        rdata_d = ERROR_DATA;
                        dv_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign master.data_in    = rdata_q;
    assign master.data_valid = dv_q;
    assign master.busy       = busy_q;
    assign slave.address     = addr_q;
    assign slave.data_out    = wdata_q;
    assign slave.rnw         = rnw_q;
    assign slave.en          = sen_q;
    assign timeout_err       = terr_q;
    assign dbg_state         = state_q;

endmodule

// File: doc/biu_controller.md
Name: biu_controller

Overview:
- Bus interface unit sitting between one requesting device and one memory-mapped slave device.
- It accepts single read and write requests on the biu modport of biu_master_if and replays each request on the biu modport of biu_slave_if.
- It waits for the slave's completion and returns read data to the requester.
- A programmable response timeout prevents a dead slave from hanging the requester.

Parameters:
- ADDR_WIDTH, 32, address width of both interfaces.
- DATA_WIDTH, 32, data width of both interfaces.
- TIMEOUT_CYCLES, 16, maximum WAIT-state cycles before an aborted transfer; 0 disables the timeout.
- ERROR_DATA, 'hDEADBEEF (truncated to DATA_WIDTH), read data returned on timeout.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- master  modport  biu_master_if.biu  request side: address, data_out, rnw, en in; data_in, data_valid, busy out.
- slave  modport  biu_slave_if.biu  slave side: address, data_out, rnw, en out; data_in, data_valid in.
- timeout_err  output  1  one-cycle pulse when a transfer is aborted by timeout.

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset n_rst is asynchronous, active-low.
  - In reset, state is IDLE and all outputs are 0: master.data_in, master.data_valid, master.busy, slave.address, slave.data_out, slave.rnw, slave.en, timeout_err. The timeout counter is also 0.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - busy=0.
  - master.en=1 latches address, data_out and rnw into slave.address, slave.data_out and slave.rnw, then moves to REQ.
  - slave.data_valid is ignored in IDLE.
- REQ (exactly 1 cycle):
  - slave.en=1, busy=1, counter cleared.
  - slave.data_valid is not sampled; the earliest slave response is the cycle after en.
  - Moves to WAIT.
- WAIT:
  - slave.en=0, busy=1. Address, data and rnw are held stable.
  - slave.data_valid=1 completes the transfer. For a read, slave.data_in is registered into master.data_in. Moves to RESP.
  - If TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES-1 with slave.data_valid=0, the transfer aborts. For a read, master.data_in is set to ERROR_DATA. timeout_err is set for the RESP cycle. Moves to RESP.
  - If not aborting, the counter increments (width $clog2(TIMEOUT_CYCLES+1)). WAIT therefore lasts at most TIMEOUT_CYCLES cycles.
  - If slave.data_valid and the timeout threshold coincide, normal completion wins and timeout_err stays 0.
- RESP (1 cycle):
  - busy=0. master.data_valid=1 only for reads (normal or timeout). timeout_err=1 only if the transfer was aborted.
  - master.en=1 in RESP is accepted exactly as in IDLE, giving back-to-back transfers. Otherwise the FSM returns to IDLE.
- Write completion is signalled only by busy falling; master.data_valid stays 0 for writes.
- master.data_in holds its last value until the next read completes.
- master.en asserted while busy=1 (REQ or WAIT) is ignored; the device must re-present the request later.
- Minimum read latency: en sampled at edge 0, slave.en high in cycle 1, slave data_valid in cycle 2, master.data_valid in cycle 3.
- Reset asserted mid-transfer abandons the transfer immediately with outputs as above. No response is generated, and a late slave.data_valid after reset release is ignored (IDLE).

Test Plan:
1. Read: en with address 0x1000, rnw=1; slave returns data_valid with 0x12345678 one cycle after slave.en. Required: slave.en high exactly 1 cycle with address 0x1000 and rnw=1; master.data_valid high 1 cycle, 3 cycles after en; data_in=0x12345678; busy low in that RESP cycle.
2. Write: address 0x20, data 0xA5A5A5A5; slave acks 4 cycles after slave.en. Required: slave.data_out=0xA5A5A5A5, rnw=0; busy=1 through REQ and WAIT; master.data_valid never asserts; timeout_err=0.
3. Timeout (TIMEOUT_CYCLES=16): read to a silent slave. Required: after 16 WAIT cycles, timeout_err and master.data_valid pulse together for 1 cycle with data_in=0xDEADBEEF; FSM returns to IDLE.
4. Boundary: slave.data_valid with 0x55 on the 16th WAIT cycle. Required: normal completion with data_in=0x55 and timeout_err=0.
5. Handshake: master.en with address 0x40 during WAIT is ignored, and slave.address stays at the original value. Then en with address 0x44 during the RESP cycle is accepted, with slave.en for 0x44 one cycle later.
6. Reset: n_rst low during WAIT. Required: all outputs 0 asynchronously. After release, a slave.data_valid pulse produces no master.data_valid and busy stays 0.
